// File: rtl/pcu.sv
// Program counter unit: 16-bit fetch address with increment, signed 8-bit
// relative branch, and two-byte absolute jump staged over the 8-bit bus.
module pcu #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  d,
  input  logic        ll,
  input  logic        lh,
  input  logic        br,
  input  logic        inc,
  output logic [15:0] a,
  output logic        pend,
  output logic        wrap
);

  typedef enum logic {IDLE, LOPEND} state_t;

  state_t      r_state;
  logic [7:0]  r_lo;
  logic [15:0] r_a;
  logic        r_wrap;
  logic [16:0] w_br_sum;
  logic [16:0] w_inc_sum;

  // Bit 16 of the 17-bit sum flags a wrap in both directions: carry for a
  // positive offset, borrow for a negative one (sign extension makes it so).
  assign w_br_sum  = {1'b0, r_a} + {{9{d[7]}}, d};
  assign w_inc_sum = {1'b0, r_a} + 17'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= RESET_VECTOR;
      r_lo    <= 8'h00;
      r_state <= IDLE;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (lh) begin
        if (ll) begin
          r_a  <= {d, d};
          r_lo <= d;
        end else if (r_state == LOPEND) begin
          r_a <= {d, r_lo};
        end else begin
          r_a <= {d, r_a[7:0]};
        end
        r_state <= IDLE;
      end else begin
        if (br) begin
          r_a    <= w_br_sum[15:0];
          r_wrap <= w_br_sum[16];
        end else if (inc) begin
          r_a    <= w_inc_sum[15:0];
          r_wrap <= w_inc_sum[16];
        end
        if (ll) begin
          r_lo    <= d;
          r_state <= LOPEND;
        end
      end
    end
  end

  assign a    = r_a;
  assign wrap = r_wrap;
  assign pend = (r_state == LOPEND);

endmodule
